addr_pipe: RTL

//  Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit adder in the ALU path.

---
 rtl/addr_pipe_if.sv | 16 +
 rtl/addr_pipe.sv | 86 ++++++++
 2 files changed

// File: rtl/addr_pipe_if.sv
// addr_pipe_if: operand/result handshake bundle for the pipelined adder
interface addr_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid, in_ready, c_in, sub;
    logic             out_valid, out_ready, ADDRc_out, ovf, zero;
    logic [WIDTH-1:0] a, b, ADDRout;
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, ADDRout, ADDRc_out, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, ADDRout, ADDRc_out, ovf, zero
    );
endinterface

// File: rtl/addr_pipe.sv
// addr_pipe: pipelined add/subtract, one SW-bit slice per stage with registered carry
module addr_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    addr_pipe_if.slave p
);
    localparam int SW = WIDTH / STAGES;
    logic             adv;
    logic             zero_r, ovf_r;
    logic [WIDTH-1:0] b_eff;
    assign b_eff      = p.sub ? ~p.b : p.b;
    assign adv        = !p.out_valid || p.out_ready;
    assign p.in_ready = adv;
    for (genvar k = 0; k < STAGES; k++) begin : st
        logic                v, c, ci, vi;
        logic [SW-1:0]       sa, sb;
        logic [SW:0]         s;
        logic [(k+1)*SW-1:0] rn, r;
        if (k == 0) begin : src
            assign sa = p.a[SW-1:0];
            assign sb = b_eff[SW-1:0];
            assign ci = p.sub | p.c_in;
            assign vi = p.in_valid;
            assign rn = s[SW-1:0];
        end else begin : src
            assign sa = st[k-1].hi.ua[k*SW +: SW];
            assign sb = st[k-1].hi.ub[k*SW +: SW];
            assign ci = st[k-1].c;
            assign vi = st[k-1].v;
            assign rn = {s[SW-1:0], st[k-1].r};
        end
        assign s = {1'b0, sa} + {1'b0, sb} + {{SW{1'b0}}, ci};
        // slice sum, carry and valid advance together; the whole pipe holds on stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                c <= 1'b0;
                r <= '0;
            end else if (adv) begin
                v <= vi;
                c <= s[SW];
                r <= rn;
            end
        end
        if (k < STAGES - 1) begin : hi
            logic [WIDTH-1:(k+1)*SW] ua, ub, na, nb;
            if (k == 0) begin : nx
                assign na = p.a[WIDTH-1:SW];
                assign nb = b_eff[WIDTH-1:SW];
            end else begin : nx
                assign na = st[k-1].hi.ua[WIDTH-1:(k+1)*SW];
                assign nb = st[k-1].hi.ub[WIDTH-1:(k+1)*SW];
            end
            // operand slices not yet added ride along until their stage consumes them
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ua <= '0;
                    ub <= '0;
                end else if (adv) begin
                    ua <= na;
                    ub <= nb;
                end
            end
        end
        if (k == STAGES - 1) begin : fl
            // flags come from the last slice, which holds the operand and result sign bits
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    zero_r <= 1'b0;
                    ovf_r  <= 1'b0;
                end else if (adv) begin
                    zero_r <= ~|rn;
                    ovf_r  <= (sa[SW-1] == sb[SW-1]) && (s[SW-1] != sa[SW-1]);
                end
            end
        end
    end
    assign p.out_valid = st[STAGES-1].v;
    assign p.ADDRout   = st[STAGES-1].r;
    assign p.ADDRc_out = st[STAGES-1].c;
    assign p.ovf       = ovf_r;
    assign p.zero      = zero_r;
endmodule
